i2c_master: RTL and testbench

I2C_MASTER -- requirements
Module: i2c_master

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_master_if.sv | 16 +
 rtl/i2c_qtr_tick.sv | 32 +++
 rtl/i2c_master.sv | 144 ++++++++++++++
 tb/tb_i2c_master.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master.
package i2c_pkg;

  localparam int   QTR_DEF = 250;   // 100 kHz SCL from a 100 MHz clk
  localparam logic ACK     = 1'b0;
  localparam logic NACK    = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_NACK,
    S_STOP
  } state_t;

endpackage

// File: rtl/i2c_master_if.sv
// Request/response handshake between a host and the I2C master.
interface i2c_master_if;
  logic       start;
  logic       rw;
  logic [6:0] slave_addr;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       busy;
  logic       done;
  logic       ack_error;

  modport master (input  start, rw, slave_addr, tx_data,
                  output rx_data, busy, done, ack_error);
  modport slave  (output start, rw, slave_addr, tx_data,
                  input  rx_data, busy, done, ack_error);
endinterface

// File: rtl/i2c_qtr_tick.sv
// SCL quarter-period timebase: a tick on the last clk of each quarter and
// the 2-bit index of the quarter currently running.
module i2c_qtr_tick #(
  parameter int CLK_PER_QTR = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  output logic       tick,
  output logic [1:0] qtr
);

  localparam int CW = (CLK_PER_QTR > 1) ? $clog2(CLK_PER_QTR) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLK_PER_QTR - 1));

  // Divider and quarter index; clr realigns both to the start of q0.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      qtr <= '0;
    end else if (tick) begin
      cnt <= '0;
      qtr <= qtr + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, address+rw, one data byte, ACK/NACK, STOP.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int CLK_PER_QTR = QTR_DEF,
  parameter bit STRETCH_EN  = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  i2c_master_if.master bus,
  output logic         scl,
  inout  wire          sda,
  output logic [3:0]   debug_state
);

  // SCL is push-pull and never read back, so the stretch option has no logic.
  if (STRETCH_EN) begin : g_stretch_rsvd
  end

  state_t     state, nstate;
  logic [1:0] qtr;
  logic       tick, accept, slot_end, samp;
  logic [2:0] bit_cnt;
  logic [7:0] sh, rx_sh, tx_q, rx_q;
  logic       rw_q, ack_err_q, done_q;
  logic       scl_o, sda_low, sda_in;

  // A start landing on the done cycle is held off until the next cycle.
  assign accept   = (state == S_IDLE) && bus.start && !done_q;
  assign slot_end = tick && (qtr == 2'd3);
  assign samp     = tick && (qtr == 2'd2);
  assign sda_in   = sda;

  i2c_qtr_tick #(.CLK_PER_QTR(CLK_PER_QTR)) u_qtr (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .tick(tick),
    .qtr (qtr)
  );

  // State, shift registers and result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      sh        <= '0;
      rx_sh     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rw_q      <= 1'b0;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state  <= nstate;
      done_q <= (state == S_STOP) && slot_end;
      if (accept) begin
        rw_q      <= bus.rw;
        tx_q      <= bus.tx_data;
        sh        <= {bus.slave_addr, bus.rw};
        ack_err_q <= 1'b0;
        bit_cnt   <= '0;
      end
      if (samp) begin
        case (state)
          S_ADDR_ACK, S_WR_ACK: if (sda_in == NACK) ack_err_q <= 1'b1;
          S_RD_DATA:            rx_sh <= {rx_sh[6:0], sda_in};
          default: ;
        endcase
      end
      if (slot_end) begin
        case (state)
          S_ADDR, S_WR_DATA: begin
            sh      <= {sh[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
          end
          S_ADDR_ACK: begin
            sh      <= tx_q;
            bit_cnt <= '0;
          end
          S_RD_DATA: bit_cnt <= bit_cnt + 3'd1;
          S_RD_NACK: rx_q    <= rx_sh;
          default: ;
        endcase
      end
    end
  end

  // Next state and the SCL/SDA waveform for the current quarter.
  always_comb begin
    nstate  = state;
    scl_o   = 1'b1;
    sda_low = 1'b0;
    unique case (state)
      S_IDLE: if (accept) nstate = S_START;
      S_START: begin
        scl_o   = (qtr != 2'd3);
        sda_low = qtr[1];
        if (slot_end) nstate = S_ADDR;
      end
      S_ADDR: begin
        scl_o   = qtr[1];
        sda_low = ~sh[7];
        if (slot_end && bit_cnt == 3'd7) nstate = S_ADDR_ACK;
      end
      S_ADDR_ACK: begin
        scl_o = qtr[1];
        if (slot_end) nstate = ack_err_q ? S_STOP : (rw_q ? S_RD_DATA : S_WR_DATA);
      end
      S_WR_DATA: begin
        scl_o   = qtr[1];
        sda_low = ~sh[7];
        if (slot_end && bit_cnt == 3'd7) nstate = S_WR_ACK;
      end
      S_WR_ACK: begin
        scl_o = qtr[1];
        if (slot_end) nstate = S_STOP;
      end
      S_RD_DATA: begin
        scl_o = qtr[1];
        if (slot_end && bit_cnt == 3'd7) nstate = S_RD_NACK;
      end
      S_RD_NACK: begin
        scl_o = qtr[1];
        if (slot_end) nstate = S_STOP;
      end
      S_STOP: begin
        scl_o   = (qtr != 2'd0);
        sda_low = ~qtr[1];
        if (slot_end) nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  assign scl           = scl_o;
  assign sda           = sda_low ? 1'b0 : 1'bz;
  assign debug_state   = state;
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = done_q;
  assign bus.ack_error = ack_err_q;
  assign bus.rx_data   = rx_q;

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: clocked slave model on the bus, expectations from
// slot arithmetic and the slave's register contents.
module tb_i2c_master;
  import i2c_pkg::*;

  localparam int Q = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl;
  wire        sda;
  logic [3:0] dbg;
  int         n_chk = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  i2c_master_if bus ();

  i2c_master #(.CLK_PER_QTR(Q), .STRETCH_EN(1'b0)) dut (
    .clk(clk), .rst(rst), .bus(bus), .scl(scl), .sda(sda), .debug_state(dbg)
  );

  pullup u_pu (sda);

  // Slave model: answers 0x57 and 0x5A; 0x5A NACKs write data.
  logic       s_drv = 1'b0;
  logic       s_act = 1'b0, s_match = 1'b0, s_rw = 1'b0;
  logic       scl_d = 1'b1, sda_d = 1'b1;
  logic [7:0] s_sh = '0, s_addr_byte = '0, s_wr_byte = '0;
  logic [7:0] s_mem [128];
  int         s_scnt = 0, s_starts = 0, s_stops = 0, s_wr_cnt = 0;
  int         cyc = 0, s_rise0 = 0, s_rise1 = 0;
  logic [7:0] exp_rx = '0;

  assign sda = s_drv ? 1'b0 : 1'bz;

  function automatic logic responds(input logic [6:0] a);
    return (a == 7'h57) || (a == 7'h5A);
  endfunction

  // Slave: START/STOP detection, bit capture on SCL rise, drive on SCL fall.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    scl_d <= scl;
    sda_d <= sda;
    if (rst) begin
      s_act <= 1'b0; s_drv <= 1'b0; s_scnt <= 0;
    end else if (scl && scl_d && sda_d && !sda) begin
      s_act <= 1'b1; s_drv <= 1'b0; s_scnt <= 0; s_starts <= s_starts + 1;
    end else if (scl && scl_d && !sda_d && sda) begin
      if (s_act) s_stops <= s_stops + 1;
      s_act <= 1'b0; s_drv <= 1'b0;
    end else if (s_act && scl && !scl_d) begin
      if (s_scnt != 8 && s_scnt < 17) s_sh <= {s_sh[6:0], sda};
      if (s_scnt == 7) begin
        s_addr_byte <= {s_sh[6:0], sda};
        s_match     <= responds(s_sh[6:0]);
        s_rw        <= sda;
      end
      if (s_scnt == 16 && s_match && !s_rw) begin
        s_wr_byte <= {s_sh[6:0], sda};
        s_wr_cnt  <= s_wr_cnt + 1;
      end
      if (s_scnt == 0) s_rise0 <= cyc;
      if (s_scnt == 1) s_rise1 <= cyc;
      s_scnt <= s_scnt + 1;
    end else if (s_act && !scl && scl_d) begin
      if (s_scnt == 8)
        s_drv <= s_match;
      else if (s_scnt >= 9 && s_scnt <= 16)
        s_drv <= s_match && s_rw && !s_mem[s_addr_byte[7:1]][3'(16 - s_scnt)];
      else if (s_scnt == 17)
        s_drv <= s_match && !s_rw && (s_addr_byte[7:1] != 7'h5A);
      else
        s_drv <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One transaction; poke >= 0 pulses a stray start that many cycles after
  // accept; chain re-requests on the done cycle and runs it a second time.
  task automatic run_txn(input logic r, input logic [6:0] a, input logic [7:0] d,
                         input int poke, input bit chain);
    bit addr_ok, exp_err;
    int slots, n, gap, st0, sp0, wc0, extra;
    addr_ok = responds(a);
    exp_err = !addr_ok || (!r && a == 7'h5A);
    // START + 8 address + ACK [+ 8 data + ACK/NACK] + STOP
    slots   = addr_ok ? 20 : 11;
    if (addr_ok && r) exp_rx = s_mem[a];
    @(negedge clk);
    bus.start = 1'b1; bus.rw = r; bus.slave_addr = a; bus.tx_data = d;
    for (int rep = 0; rep < (chain ? 2 : 1); rep++) begin
      st0 = s_starts; sp0 = s_stops; wc0 = s_wr_cnt;
      @(negedge clk);
      bus.start = 1'b0;
      chk("busy_on", bus.busy, 1'b1);
      chk("ackerr_clr", bus.ack_error, 1'b0);
      n = 0; gap = 0;
      while (!bus.done && n < 100 * Q) begin
        if (n == poke) begin
          bus.start = 1'b1; bus.rw = ~r; bus.slave_addr = a ^ 7'h11; bus.tx_data = ~d;
        end
        @(negedge clk);
        bus.start = 1'b0;
        n++;
        if (!bus.busy && !bus.done) gap++;
      end
      // done is visible in the first cycle after the last quarter ends
      chk("latency", n, 4 * slots * Q);
      chk("ack_error", bus.ack_error, exp_err);
      chk("rx_data", bus.rx_data, exp_rx);
      chk("addr_byte", s_addr_byte, {a, r});
      chk("one_start", s_starts - st0, 1);
      chk("stop_seen", s_stops - sp0, 1);
      chk("wr_cnt", s_wr_cnt - wc0, (addr_ok && !r) ? 1 : 0);
      if (addr_ok && !r) chk("wr_byte", s_wr_byte, d);
      chk("scl_period", s_rise1 - s_rise0, 4 * Q);
      chk("busy_gap", gap, 0);
      if (rep == 0 && chain) begin
        bus.start = 1'b1; bus.rw = r; bus.slave_addr = a; bus.tx_data = d;
        @(negedge clk);
        chk("start_on_done", bus.busy, 1'b0);
      end
    end
    @(negedge clk);
    chk("done_pulse", bus.done, 1'b0);
    chk("ackerr_hold", bus.ack_error, exp_err);
    chk("bus_idle", {scl, sda}, 2'b11);
    extra = 0;
    repeat (4 * Q) begin
      @(negedge clk);
      if (bus.busy) extra++;
    end
    chk("no_queue", extra, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog n_err=%0d n_chk=%0d", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, bad, sp0, pk;
    logic [6:0] ra;
    bus.start = 1'b0; bus.rw = 1'b0; bus.slave_addr = '0; bus.tx_data = '0;
    for (int i = 0; i < 128; i++) s_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_scl", scl, 1'b1);
    chk("rst_sda", sda, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_ackerr", bus.ack_error, 1'b0);
    chk("rst_rx", bus.rx_data, 8'h00);
    chk("rst_state", dbg, S_IDLE);
    rst = 1'b0;

    s_mem[7'h57] = 8'hA5;
    run_txn(1'b1, 7'h57, 8'h00, -1, 1'b0);
    run_txn(1'b0, 7'h57, 8'h3C, -1, 1'b0);
    run_txn(1'b1, 7'h12, 8'h00, -1, 1'b0);
    s_mem[7'h57] = 8'h5C;
    run_txn(1'b1, 7'h57, 8'h00, 6 * Q, 1'b0);
    run_txn(1'b0, 7'h5A, 8'h77, -1, 1'b1);

    // Reset in the middle of the read data byte
    s_mem[7'h57] = 8'h96;
    sp0 = s_stops;
    @(negedge clk);
    bus.start = 1'b1; bus.rw = 1'b1; bus.slave_addr = 7'h57;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (s_scnt < 12 && n < 100 * Q) begin
      @(negedge clk);
      n++;
    end
    chk("reach_rd", (s_scnt >= 12), 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_scl", scl, 1'b1);
    chk("abort_sda", sda, 1'b1);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_rx", bus.rx_data, 8'h00);
    chk("abort_state", dbg, S_IDLE);
    exp_rx = 8'h00;
    bad = 0;
    repeat (3 * Q) begin
      @(negedge clk);
      if (!scl || !sda || bus.busy) bad++;
    end
    chk("abort_idle", bad, 0);
    chk("abort_no_stop", s_stops - sp0, 0);
    s_mem[7'h5A] = 8'hC3;
    run_txn(1'b1, 7'h5A, 8'h00, -1, 1'b0);

    // Randomised traffic
    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = 7'h57;
        1:       ra = 7'h5A;
        default: ra = 7'($urandom);
      endcase
      s_mem[ra] = 8'($urandom);
      pk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 30 * Q)) : -1;
      run_txn(1'($urandom), ra, 8'($urandom), pk, ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
